// File: rtl/dram_pkg.sv
// Shared defaults and encodings for the 4x72 data-memory model.
// Optional feature macro: DRAM_PARITY_EN (per-word even parity + parity_err).
package dram_pkg;
    localparam int DRAM_WIDTH  = 72;
    localparam int DRAM_DEPTH  = 4;
    localparam int DRAM_ADDR_W = 2;

    // Write_ReadCOMP encoding
    localparam logic WR = 1'b1;
    localparam logic RD = 1'b0;
endpackage

// File: rtl/dram_if.sv
// Bus bundle for dram_4x72: address/data/control in, registered data out.
// Optional feature macro: DRAM_PARITY_EN adds parity_err.
interface dram_if
    import dram_pkg::*;
#(
    parameter int WIDTH  = DRAM_WIDTH,
    parameter int ADDR_W = DRAM_ADDR_W
);
    logic [ADDR_W-1:0] address;
    logic [WIDTH-1:0]  dataIN;
    logic              Write_ReadCOMP;
    logic [WIDTH-1:0]  dataOUT;
`ifdef DRAM_PARITY_EN
    logic              parity_err;

    modport master (output address, dataIN, Write_ReadCOMP, input dataOUT, parity_err);
    modport slave  (input address, dataIN, Write_ReadCOMP, output dataOUT, parity_err);
`else
    modport master (output address, dataIN, Write_ReadCOMP, input dataOUT);
    modport slave  (input address, dataIN, Write_ReadCOMP, output dataOUT);
`endif
endinterface

// File: rtl/dram_parity_gen.sv
// Even-parity generator: XOR-reduce of a data word.
module dram_parity_gen #(
    parameter int WIDTH = 72
) (
    input  logic [WIDTH-1:0] data,
    output logic             parity
);
    assign parity = ^data;
endmodule

// File: rtl/dram_4x72.sv
// 4 x 72 word-addressed storage with registered read and hold-on-write output.
// Optional feature macro: DRAM_PARITY_EN (stored even parity, registered parity_err).
module dram_4x72
    import dram_pkg::*;
#(
    parameter int WIDTH  = DRAM_WIDTH,
    parameter int DEPTH  = DRAM_DEPTH,
    parameter int ADDR_W = DRAM_ADDR_W
) (
    input  logic clk,
    input  logic rst,
    dram_if.slave bus
);
    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [WIDTH-1:0]            dout_q, dout_d;
    logic [WIDTH-1:0]            rd_word;

    assign rd_word = mem_q[bus.address];

`ifdef DRAM_PARITY_EN
    logic [DEPTH-1:0] par_q, par_d;
    logic             perr_q, perr_d;
    logic             wr_par, rd_par;

    dram_parity_gen #(.WIDTH(WIDTH)) u_wr_par (.data(bus.dataIN), .parity(wr_par));
    dram_parity_gen #(.WIDTH(WIDTH)) u_rd_par (.data(rd_word),    .parity(rd_par));

    assign bus.parity_err = perr_q;
`endif

    // Next-state: write updates the array only; anything that is not a clean
    // write (including an unknown control) behaves as a read.
    always_comb begin
        mem_d  = mem_q;
        dout_d = dout_q;
`ifdef DRAM_PARITY_EN
        par_d  = par_q;
        perr_d = perr_q;
`endif
        if (bus.Write_ReadCOMP == WR) begin
            mem_d[bus.address] = bus.dataIN;
`ifdef DRAM_PARITY_EN
            par_d[bus.address] = wr_par;
`endif
        end else begin
            dout_d = rd_word;
`ifdef DRAM_PARITY_EN
            perr_d = rd_par != par_q[bus.address];
`endif
        end
    end

    // State registers; synchronous reset wins over any coincident write.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q  <= '0;
            dout_q <= '0;
`ifdef DRAM_PARITY_EN
            par_q  <= '0;
            perr_q <= 1'b0;
`endif
        end else begin
            mem_q  <= mem_d;
            dout_q <= dout_d;
`ifdef DRAM_PARITY_EN
            par_q  <= par_d;
            perr_q <= perr_d;
`endif
        end
    end

    assign bus.dataOUT = dout_q;
endmodule

// File: tb/tb_dram_4x72.sv
// Scoreboard bench for dram_4x72: driver updates a behavioural memory model
// and queues the expected output for every clock; monitor pops and compares.
module tb_dram_4x72;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    dram_if bus ();

    dram_4x72 dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [71:0] d;
        logic        pe;
        string       name;
    } exp_t;

    exp_t        q[$];
    logic [71:0] m[4];
    bit          bad[4];
    logic [71:0] mdout;
    logic        mpe;
    int          errors = 0;
    int          checks = 0;
    string       tag = "init";

    // One clock of stimulus; model result is what dataOUT must show after the edge.
    task automatic cyc(input logic r, input logic w, input logic [1:0] a, input logic [71:0] d);
        @(negedge clk);
        rst = r;
        bus.Write_ReadCOMP = w;
        bus.address = a;
        bus.dataIN = d;
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                m[i] = '0;
                bad[i] = 1'b0;
            end
            mdout = '0;
            mpe = 1'b0;
        end else if (w) begin
            m[a] = d;
            bad[a] = 1'b0;
        end else begin
            mdout = m[a];
            mpe = bad[a];
        end
        q.push_back('{mdout, mpe, tag});
    endtask

    // Monitor: one expected entry per edge once the driver has started.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                checks++;
                if (bus.dataOUT !== e.d) begin
                    errors++;
                    $display("FAIL %s dataOUT got=%h exp=%h", e.name, bus.dataOUT, e.d);
                end
`ifdef DRAM_PARITY_EN
                checks++;
                if (bus.parity_err !== e.pe) begin
                    errors++;
                    $display("FAIL %s parity_err got=%b exp=%b", e.name, bus.parity_err, e.pe);
                end
`endif
            end
        end
    end

    initial begin
        logic [95:0] rnd;
        bus.Write_ReadCOMP = 1'b0;
        bus.address = '0;
        bus.dataIN = '0;
        mdout = '0;
        mpe = 1'b0;

        tag = "reset";
        cyc(1'b1, 1'b0, 2'd0, 72'd0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 2'(i), 72'd5);

        tag = "wr_rd";
        cyc(1'b0, 1'b1, 2'd2, 72'd12);
        cyc(1'b0, 1'b1, 2'd3, 72'd23);
        cyc(1'b0, 1'b0, 2'd3, 72'd0);
        cyc(1'b0, 1'b0, 2'd2, 72'd0);

        tag = "hold_on_write";
        cyc(1'b0, 1'b0, 2'd3, 72'd0);
        cyc(1'b0, 1'b1, 2'd0, 72'hFF);
        cyc(1'b0, 1'b0, 2'd0, 72'd0);

        tag = "rst_priority";
        cyc(1'b0, 1'b1, 2'd1, 72'd44);
        cyc(1'b1, 1'b1, 2'd1, 72'd99);
        cyc(1'b0, 1'b0, 2'd1, 72'd0);

        tag = "full_width";
        cyc(1'b0, 1'b1, 2'd1, 72'hFF_FFFF_FFFF_FFFF_FFFF);
        cyc(1'b0, 1'b0, 2'd1, 72'd0);
        cyc(1'b0, 1'b1, 2'd2, 72'hA5_0000_0000_0000_0001);
        cyc(1'b0, 1'b0, 2'd2, 72'd0);

`ifdef DRAM_PARITY_EN
        tag = "parity_ok";
        cyc(1'b0, 1'b1, 2'd0, 72'd7);
        cyc(1'b0, 1'b0, 2'd0, 72'd0);
        // Corrupt a stored bit of word 0 between edges.
        @(posedge clk);
        #2;
        dut.mem_q[0][3] = ~dut.mem_q[0][3];
        m[0][3] = ~m[0][3];
        bad[0] = 1'b1;
        tag = "parity_err";
        cyc(1'b0, 1'b0, 2'd0, 72'd0);
        cyc(1'b0, 1'b1, 2'd1, 72'd3);
        tag = "parity_hold";
        cyc(1'b0, 1'b0, 2'd1, 72'd0);
        tag = "parity_rewrite";
        cyc(1'b0, 1'b1, 2'd0, 72'd9);
        cyc(1'b0, 1'b0, 2'd0, 72'd0);
`endif

        tag = "random";
        for (int n = 0; n < 300; n++) begin
            rnd = {$urandom, $urandom, $urandom};
            cyc(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), rnd[71:0]);
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending got=%0d exp=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
